sgd_main: RTL and testbench
===========================

Name: sgd_main

Overview:
- Stochastic-gradient-descent linear-regression trainer.
- Receives a training set over a single serial line into internal storage, then runs `epoch` passes of per-sample weight updates on signed Q8.8 data.
- Exposes the trained weights through a read port and raises SGD_DONE when training finishes.
- Top-level compute block; a host or bench drives the run configuration and the serial stream.

Parameters:
- W, 16, data/weight word width (signed Q8.8).
- MAX_FEAT, 11, maximum number of features per sample.
- WPR, 12, words per sample row (1 target + MAX_FEAT features).
- MAX_POINTS, 16, sample storage depth.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  asynchronous, active-low reset.
- S  in  1  serial data, one bit per rising CLK edge.
- feat  in  4  number of active features (1..11).
- epoch  in  8  number of training passes.
- data_points  in  12  number of samples to load and train on.
- learn_rate  in  4  learning-rate right-shift amount.
- w_sel  in  4  weight read select: 0..10 = w[k], 11 = bias.
- w_out  out  W  selected weight, combinational.
- SGD_DONE  out  1  training complete, sticky until reset.

Behaviour:
- Reset (RST=0, async):
  - All weights and bias = 0; SGD_DONE = 0; counters = 0; state = LOAD.
  - Reset mid-run aborts everything and restarts at LOAD.
- Config inputs are sampled when leaving LOAD and held internally.
  - feat > 11 clamps to 11; feat = 0 means bias-only.
  - data_points > MAX_POINTS clamps to MAX_POINTS.
- LOAD:
  - Starts at the first rising edge with RST=1 and shifts S on every edge.
  - Stream order: sample 0 first. Within a sample, word 11 first down to word 0. Each word is sent LSB first (16 bits).
  - Word 0 = target y; word k (1..11) = feature x[k-1].
  - LOAD lasts data_points*12*16 cycles, then goes to PRED.
  - data_points = 0 or epoch = 0: go directly to DONE after LOAD, with weights still 0.
- PRED:
  - acc = bias, then one MAC per cycle: acc += (w[k]*x[k]) >>> 8, for k = 0..feat-1.
  - Full-precision 32-bit products, arithmetic shift.
  - Takes feat+1 cycles.
- ERR (1 cycle): err = sat16(acc - y).
- UPD: one term per cycle.
  - w[k] = sat16(w[k] - (((err*x[k]) >>> 8) >>> learn_rate)).
  - bias = sat16(bias - (err >>> learn_rate)).
  - Takes feat+1 cycles. All updates use the err value latched in ERR.
- NEXT: advance sample index.
  - At the last sample, wrap the index to 0 and increment the epoch counter.
  - At the last epoch, go to DONE; otherwise go to PRED.
- DONE:
  - SGD_DONE = 1, weights frozen; S is ignored.
  - Stays in DONE until reset.
- sat16 saturates to the range [0x8000, 0x7FFF].
- w_out is valid in any state; in DONE it is final.
- w_sel > 11 returns 0.

Decomposition:
- Shared package sgd_pkg holds:
  - W, MAX_FEAT, WPR, MAX_POINTS.
  - State enum {LOAD, PRED, ERR, UPD, NEXT, DONE}.
  - Q8.8 FRAC = 8 constant.
  - sat16 function.
- One natural sub-module, sgd_serial_loader: bit/word/sample counters, shift register, and write port into sample memory, asserting load_done.

Test Plan:
- Reset: RST=0 mid-LOAD, then release → SGD_DONE=0 and all w_out=0; loading restarts at sample 0.
- One epoch: feat=1, data_points=1, epoch=1, lr=0; stream x0=0x0100, y=0x0200, other words 0.
  - Required: SGD_DONE rises about 192+5 cycles after reset release.
  - Required: w[0]=0x0200, bias=0x0200.
- Same data with epoch=2 → pred=0x0400, err=0x0200 → w[0]=0x0000, bias=0x0000.
- Epoch=0 or data_points=0 → SGD_DONE asserts right after LOAD; all weights 0.
- Saturation: feat=1, lr=0, x0=0x7F00, y=0x7F00, epoch=3.
  - Required: weights clamp to 0x7FFF/0x8000 and never wrap.
- Full case: feat=11, data_points=4, epoch=100, lr=15, 4×12 words.
  - Required: SGD_DONE asserts exactly once.
  - Required: weights match the reference model bit-exactly.

Source files
------------

// File: rtl/sgd_pkg.sv
// Shared constants, FSM state encoding and Q8.8 saturation for the SGD trainer.
package sgd_pkg;
    localparam int W          = 16;
    localparam int MAX_FEAT   = 11;
    localparam int WPR        = 12;
    localparam int MAX_POINTS = 16;
    localparam int FRAC       = 8;

    typedef enum logic [2:0] {LOAD, PRED, ERR, UPD, NEXT, DONE} state_t;

    function automatic logic signed [W-1:0] sat16(input logic signed [31:0] v);
        if (v > 32'sd32767)
            return 16'sh7FFF;
        else if (v < -32'sd32768)
            return 16'sh8000;
        else
            return v[W-1:0];
    endfunction
endpackage

// File: rtl/sgd_serial_loader.sv
// Deserialises the training stream (LSB first, word 11 down to 0, sample 0 first) into sample memory writes.
module sgd_serial_loader
    import sgd_pkg::*;
(
    input  logic         CLK,
    input  logic         RST,
    input  logic         active,
    input  logic         S,
    input  logic [4:0]   n_points,
    output logic         wr_en,
    output logic [3:0]   wr_samp,
    output logic [3:0]   wr_word,
    output logic [W-1:0] wr_data,
    output logic         load_done
);
    logic [3:0]   bit_cnt;
    logic [3:0]   word_cnt;
    logic [4:0]   samp_cnt;
    logic [W-1:0] shreg;
    logic         shift;

    assign load_done = (samp_cnt == n_points);
    assign shift     = active && !load_done;
    assign wr_en     = shift && (bit_cnt == 4'd15);
    assign wr_data   = {S, shreg[W-1:1]};
    assign wr_word   = word_cnt;
    assign wr_samp   = samp_cnt[3:0];

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            bit_cnt  <= '0;
            word_cnt <= 4'(WPR - 1);
            samp_cnt <= '0;
        end else if (shift) begin
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd15) begin
                if (word_cnt == 4'd0) begin
                    word_cnt <= 4'(WPR - 1);
                    samp_cnt <= samp_cnt + 5'd1;
                end else begin
                    word_cnt <= word_cnt - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (shift)
            shreg <= {S, shreg[W-1:1]};
    end
endmodule

// File: rtl/sgd_main.sv
// SGD linear-regression trainer: serial load, then per-sample predict / error / update over the epochs.
module sgd_main
    import sgd_pkg::*;
(
    input  logic         CLK,
    input  logic         RST,
    input  logic         S,
    input  logic [3:0]   feat,
    input  logic [7:0]   epoch,
    input  logic [11:0]  data_points,
    input  logic [3:0]   learn_rate,
    input  logic [3:0]   w_sel,
    output logic [W-1:0] w_out,
    output logic         SGD_DONE
);
    state_t state, state_nx;

    logic [3:0] nf_q, lr_q, idx, samp, k;
    logic [7:0] ne_q, ep_cnt;
    logic [4:0] np_q, np_c;
    logic [3:0] feat_c;

    logic signed [W-1:0] w_q [MAX_FEAT];
    logic signed [W-1:0] bias_q;
    logic signed [W-1:0] mem [MAX_POINTS][WPR];

    logic signed [W-1:0] w_k, x_k, y_k, w_new, bias_new;
    logic signed [31:0]  w_ext, x_ext, y_ext, bias_ext, err_ext, prod, eprod;
    logic signed [31:0]  acc_p0;
    logic signed [W-1:0] err_p1;

    logic         wr_en, load_done, last_samp, last_ep;
    logic [3:0]   wr_samp, wr_word;
    logic [W-1:0] wr_data;

    assign feat_c = (feat > 4'(MAX_FEAT)) ? 4'(MAX_FEAT) : feat;
    assign np_c   = (data_points > 12'(MAX_POINTS)) ? 5'(MAX_POINTS) : data_points[4:0];

    sgd_serial_loader u_loader (
        .CLK       (CLK),
        .RST       (RST),
        .active    (state == LOAD),
        .S         (S),
        .n_points  (np_c),
        .wr_en     (wr_en),
        .wr_samp   (wr_samp),
        .wr_word   (wr_word),
        .wr_data   (wr_data),
        .load_done (load_done)
    );

    always_ff @(posedge CLK) begin
        if (wr_en)
            mem[wr_samp][wr_word] <= wr_data;
    end

    // PRED walks idx 0..feat with idx 0 loading the bias, so the term index lags by one there
    always_comb begin
        k        = (state == PRED) ? idx - 4'd1 : idx;
        w_k      = (k < 4'(MAX_FEAT)) ? w_q[k] : '0;
        x_k      = (k < 4'(MAX_FEAT)) ? mem[samp][k + 4'd1] : '0;
        y_k      = mem[samp][0];
        w_ext    = w_k;
        x_ext    = x_k;
        y_ext    = y_k;
        bias_ext = bias_q;
        err_ext  = err_p1;
        prod     = w_ext * x_ext;
        eprod    = err_ext * x_ext;
        w_new    = sat16(w_ext - ((eprod >>> FRAC) >>> lr_q));
        bias_new = sat16(bias_ext - (err_ext >>> lr_q));
    end

    assign last_samp = ({1'b0, samp} == np_q - 5'd1);
    assign last_ep   = (ep_cnt == ne_q - 8'd1);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            state <= LOAD;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            LOAD: if (load_done) state_nx = (np_c == 5'd0 || epoch == 8'd0) ? DONE : PRED;
            PRED: if (idx == nf_q) state_nx = ERR;
            ERR:  state_nx = UPD;
            UPD:  if (idx == nf_q) state_nx = NEXT;
            NEXT: state_nx = (last_samp && last_ep) ? DONE : PRED;
            DONE: state_nx = DONE;
            default: state_nx = LOAD;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            nf_q   <= '0;
            ne_q   <= '0;
            np_q   <= '0;
            lr_q   <= '0;
            idx    <= '0;
            samp   <= '0;
            ep_cnt <= '0;
            bias_q <= '0;
            for (int i = 0; i < MAX_FEAT; i++)
                w_q[i] <= '0;
        end else begin
            case (state)
                LOAD: if (load_done) begin
                    nf_q   <= feat_c;
                    ne_q   <= epoch;
                    np_q   <= np_c;
                    lr_q   <= learn_rate;
                    idx    <= '0;
                    samp   <= '0;
                    ep_cnt <= '0;
                end
                PRED: idx <= (idx == nf_q) ? 4'd0 : idx + 4'd1;
                UPD: begin
                    if (idx == nf_q) begin
                        bias_q <= bias_new;
                        idx    <= '0;
                    end else begin
                        w_q[idx] <= w_new;
                        idx      <= idx + 4'd1;
                    end
                end
                NEXT: begin
                    if (last_samp) begin
                        samp   <= '0;
                        ep_cnt <= ep_cnt + 8'd1;
                    end else begin
                        samp <= samp + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // p0: dot-product accumulator; p1: error latched once per sample
    always_ff @(posedge CLK) begin
        if (state == PRED)
            acc_p0 <= (idx == 4'd0) ? bias_ext : acc_p0 + (prod >>> FRAC);
        if (state == ERR)
            err_p1 <= sat16(acc_p0 - y_ext);
    end

    always_comb begin
        w_out = '0;
        if (w_sel < 4'(MAX_FEAT))
            w_out = w_q[w_sel];
        else if (w_sel == 4'(MAX_FEAT))
            w_out = bias_q;
    end

    assign SGD_DONE = (state == DONE);
endmodule

// File: tb/tb_sgd_main.sv
// Scoreboard bench for sgd_main: directed training runs, expected weights queued, monitor checks on completion.
module tb_sgd_main;
    logic        CLK, RST, S, SGD_DONE;
    logic [3:0]  feat, learn_rate, w_sel;
    logic [7:0]  epoch;
    logic [11:0] data_points;
    logic [15:0] w_out;

    sgd_main dut (
        .CLK(CLK), .RST(RST), .S(S), .feat(feat), .epoch(epoch),
        .data_points(data_points), .learn_rate(learn_rate),
        .w_sel(w_sel), .w_out(w_out), .SGD_DONE(SGD_DONE)
    );

    typedef struct packed {
        logic             done;
        logic [11:0][15:0] w;
    } exp_t;

    exp_t  sbq[$];
    string name_q[$];
    logic signed [15:0] smem [16][12];

    int n_checks = 0, n_pass = 0;
    int mon_cnt = 0, snap_cnt = 0, done_rises = 0;
    int cyc = 0, done_cyc = 0, rel_cyc = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp_v);
    endtask

    function automatic int bsat(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic model(input int nf, input int np, input int ne, input int lr, output exp_t e);
        int w[11];
        int b, acc, err, x;
        foreach (w[i]) w[i] = 0;
        b = 0;
        for (int ep = 0; ep < ne; ep++)
            for (int s = 0; s < np; s++) begin
                acc = b;
                for (int j = 0; j < nf; j++) begin
                    x = int'(smem[s][j+1]);
                    acc = acc + ((w[j] * x) >>> 8);
                end
                err = bsat(acc - int'(smem[s][0]));
                for (int j = 0; j < nf; j++) begin
                    x = int'(smem[s][j+1]);
                    w[j] = bsat(w[j] - (((err * x) >>> 8) >>> lr));
                end
                b = bsat(b - (err >>> lr));
            end
        e.done = 1'b1;
        for (int i = 0; i < 11; i++) e.w[i] = w[i][15:0];
        e.w[11] = b[15:0];
    endtask

    // Monitor: pops one expectation per SGD_DONE rise or per snapshot request.
    initial begin
        logic  prev;
        int    snap_seen;
        exp_t  e;
        string nm;
        prev = 1'b0;
        snap_seen = 0;
        w_sel = 4'd0;
        forever begin
            @(negedge CLK);
            if ((SGD_DONE && !prev) || snap_cnt != snap_seen) begin
                if (SGD_DONE && !prev) begin
                    done_rises++;
                    done_cyc = cyc;
                end
                if (snap_cnt != snap_seen) snap_seen++;
                if (sbq.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_done: got SGD_DONE=%b with no result expected", SGD_DONE);
                end else begin
                    e  = sbq.pop_front();
                    nm = name_q.pop_front();
                    chk({nm, "_done"}, {31'd0, SGD_DONE}, {31'd0, e.done});
                    for (int i = 0; i < 14; i++) begin
                        w_sel = (i < 13) ? 4'(i) : 4'd15;
                        #1;
                        chk($sformatf("%s_w%0d", nm, w_sel), {16'd0, w_out},
                            (i < 12) ? {16'd0, e.w[i]} : 32'd0);
                        @(negedge CLK);
                    end
                    w_sel = 4'd0;
                end
                mon_cnt++;
            end
            prev = SGD_DONE;
        end
    end

    task automatic wait_mon(input string nm, input int base);
        for (int t = 0; t < 20000 && mon_cnt == base; t++) @(negedge CLK);
        if (mon_cnt == base) begin
            n_checks++;
            $display("FAIL %s_timeout: got no result after 20000 cycles, required one", nm);
            sbq.delete();
            name_q.delete();
        end
    endtask

    task automatic snap(input string nm, input exp_t e);
        int base;
        base = mon_cnt;
        sbq.push_back(e);
        name_q.push_back(nm);
        snap_cnt++;
        wait_mon(nm, base);
    endtask

    task automatic run_case(input string nm, input int f, input int dp, input int ep,
                            input int lr, input int nsamp, input exp_t e);
        int base;
        @(negedge CLK);
        RST = 1'b0;
        feat = 4'(f); data_points = 12'(dp); epoch = 8'(ep); learn_rate = 4'(lr);
        repeat (2) @(negedge CLK);
        base = mon_cnt;
        sbq.push_back(e);
        name_q.push_back(nm);
        RST = 1'b1;
        rel_cyc = cyc;
        for (int s = 0; s < nsamp; s++)
            for (int wd = 11; wd >= 0; wd--)
                for (int b = 0; b < 16; b++) begin
                    S = smem[s][wd][b];
                    @(negedge CLK);
                end
        S = 1'b1;
        wait_mon(nm, base);
    endtask

    initial begin
        exp_t zero_e, e;
        int   rises_before;
        RST = 1'b1; S = 1'b0; feat = 4'd1; epoch = 8'd1; data_points = 12'd1; learn_rate = 4'd0;
        #2 RST = 1'b0;
        repeat (3) @(negedge CLK);
        zero_e = '0;
        foreach (smem[s, wd]) smem[s][wd] = '0;

        snap("por", zero_e);

        // Reset in the middle of LOAD
        RST = 1'b1;
        repeat (100) begin
            S = 1'($urandom_range(0, 1));
            @(negedge CLK);
        end
        RST = 1'b0;
        @(negedge CLK);
        snap("midload_rst", zero_e);

        smem[0][0] = 16'sh0200;
        smem[0][1] = 16'sh0100;
        e = '0; e.done = 1'b1; e.w[0] = 16'h0200; e.w[11] = 16'h0200;
        run_case("one_epoch", 1, 1, 1, 0, 1, e);
        n_checks++;
        if (done_cyc - rel_cyc >= 192 && done_cyc - rel_cyc <= 205) n_pass++;
        else $display("FAIL one_epoch_latency: got %0d cycles required 192..205", done_cyc - rel_cyc);

        run_case("feat_clamp", 15, 1, 1, 0, 1, e);

        e = '0; e.done = 1'b1;
        run_case("two_epoch", 1, 1, 2, 0, 1, e);
        run_case("epoch0", 1, 1, 0, 0, 1, e);
        run_case("dp0", 1, 0, 1, 0, 0, e);

        smem[0][0] = 16'sh7F00;
        smem[0][1] = 16'sh7F00;
        e = '0; e.done = 1'b1; e.w[0] = 16'h7FFF; e.w[11] = 16'h7F01;
        run_case("sat", 1, 1, 3, 0, 1, e);

        for (int s = 0; s < 4; s++)
            for (int wd = 0; wd < 12; wd++)
                smem[s][wd] = 16'((((s * 5 + wd * 3) % 17) - 8) * 48);
        model(11, 4, 100, 15, e);
        rises_before = done_rises;
        run_case("full", 11, 4, 100, 15, 4, e);
        repeat (300) @(negedge CLK);
        chk("full_done_sticky", {31'd0, SGD_DONE}, 32'd1);
        chk("full_done_once", done_rises - rises_before, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
